// File: rtl/hbus_pkg.sv
// Shared definitions for the HyperRAM Wishbone arbiter and its round-robin picker.
package hbus_pkg;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } hbus_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int unsigned TMO_W = 16;

  // Index width that stays legal for a single-requester instance.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hbus_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick
  import hbus_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/hbus_wb_arbiter.sv
// Round-robin Wishbone-to-HyperRAM request arbiter with burst grant lock and
// an access watchdog that converts a stalled memory access into a bus error.
module hbus_wb_arbiter
  import hbus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned LOCK_MAX    = 16
) (
  input  logic                        wb_clk,
  input  logic                        wb_rstn,
  input  logic [NUM_MASTERS-1:0]      m_cyc,
  input  logic [NUM_MASTERS-1:0]      m_stb,
  input  logic [NUM_MASTERS-1:0]      m_we,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
  input  logic [NUM_MASTERS*3-1:0]    m_cti,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_err,
  output logic [DW-1:0]               m_rdat,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [AW-1:0]               mem_adr,
  output logic [DW-1:0]               mem_wdat,
  output logic [DW/8-1:0]             mem_sel,
  input  logic                        mem_ack,
  input  logic [DW-1:0]               mem_rdat,
  output logic                        busy,
  output logic [NUM_MASTERS-1:0]      grant
);

  localparam int unsigned IW = idx_width(NUM_MASTERS);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);

  hbus_state_e            state_q, state_d;
  logic [IW-1:0]          g_q, g_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   resp_ok_q, resp_ok_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] m_ack_q, m_ack_d;
  logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
  logic [DW-1:0]          m_rdat_q, m_rdat_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [AW-1:0]          mem_adr_q, mem_adr_d;
  logic [DW-1:0]          mem_wdat_q, mem_wdat_d;
  logic [SW-1:0]          mem_sel_q, mem_sel_d;
  logic                   busy_q, busy_d;

  logic [NUM_MASTERS-1:0] req_s;
  logic [NUM_MASTERS-1:0] pick_gnt_s;
  logic [IW-1:0]          pick_idx_s;
  logic                   pick_any_s;
  logic                   take_s;
  logic [IW-1:0]          sel_idx_s;
  logic                   lock_hold_s;
  logic [IW-1:0]          rr_next_s;

  assign req_s = m_cyc & m_stb;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr_pick (
    .req (req_s),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // A live lock bypasses the round-robin search only while its owner still requests.
  always_comb begin
    lock_hold_s = (lock_cnt_q != '0) && req_s[g_q];
    if (lock_hold_s) begin
      take_s    = 1'b1;
      sel_idx_s = g_q;
    end else begin
      take_s    = pick_any_s;
      sel_idx_s = pick_idx_s;
    end
    rr_next_s = (g_q == IW'(NUM_MASTERS - 1)) ? '0 : g_q + 1'b1;
  end

  // Next-state and registered-output computation for the ARB/REQ/RESP machine.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    resp_ok_d  = resp_ok_q;
    grant_d    = grant_q;
    m_ack_d    = '0;
    m_err_d    = '0;
    m_rdat_d   = m_rdat_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_adr_d  = mem_adr_q;
    mem_wdat_d = mem_wdat_q;
    mem_sel_d  = mem_sel_q;
    case (state_q)
      ST_ARB: begin
        if (!lock_hold_s) begin
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q;
        end
        if (take_s) begin
          g_d            = sel_idx_s;
          grant_d        = '0;
          grant_d[sel_idx_s] = 1'b1;
          mem_req_d      = 1'b1;
          mem_we_d       = m_we[sel_idx_s];
          mem_adr_d      = m_adr[sel_idx_s*AW +: AW];
          mem_wdat_d     = m_dat[sel_idx_s*DW +: DW];
          mem_sel_d      = m_sel[sel_idx_s*SW +: SW];
          tmo_cnt_d      = '0;
          state_d        = ST_REQ;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          m_rdat_d     = mem_rdat;
          mem_req_d    = 1'b0;
          resp_ok_d    = 1'b1;
          m_ack_d[g_q] = m_cyc[g_q];
          state_d      = ST_RESP;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          mem_req_d    = 1'b0;
          resp_ok_d    = 1'b0;
          m_err_d[g_q] = m_cyc[g_q];
          state_d      = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        tmo_cnt_d = '0;
        grant_d   = '0;
        state_d   = ST_ARB;
        if (resp_ok_q && (m_cti[g_q*3 +: 3] == CTI_INCR) &&
            (lock_cnt_q < LW'(LOCK_MAX - 1))) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
          lock_cnt_d = '0;
          rr_ptr_d   = rr_next_s;
        end
      end
      default: begin
        state_d   = ST_ARB;
        grant_d   = '0;
        mem_req_d = 1'b0;
        tmo_cnt_d = '0;
      end
    endcase
    busy_d = (state_d != ST_ARB);
  end

  // State and output registers; everything clears asynchronously on reset.
  always_ff @(posedge wb_clk or negedge wb_rstn) begin
    if (!wb_rstn) begin
      state_q    <= ST_ARB;
      g_q        <= '0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      resp_ok_q  <= 1'b0;
      grant_q    <= '0;
      m_ack_q    <= '0;
      m_err_q    <= '0;
      m_rdat_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_adr_q  <= '0;
      mem_wdat_q <= '0;
      mem_sel_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      resp_ok_q  <= resp_ok_d;
      grant_q    <= grant_d;
      m_ack_q    <= m_ack_d;
      m_err_q    <= m_err_d;
      m_rdat_q   <= m_rdat_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_adr_q  <= mem_adr_d;
      mem_wdat_q <= mem_wdat_d;
      mem_sel_q  <= mem_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign m_ack    = m_ack_q;
  assign m_err    = m_err_q;
  assign m_rdat   = m_rdat_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_adr  = mem_adr_q;
  assign mem_wdat = mem_wdat_q;
  assign mem_sel  = mem_sel_q;
  assign busy     = busy_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_hbus_wb_arbiter.sv
// Scoreboard bench for hbus_wb_arbiter: Wishbone master models, a HyperRAM
// responder with programmable latency, and expected grant/response queues.
module tb_hbus_wb_arbiter;

  localparam int NM   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TMO  = 8;
  localparam int LMAX = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
  logic [NM*AW-1:0]  m_adr = '0;
  logic [NM*DW-1:0]  m_dat = '0;
  logic [NM*SW-1:0]  m_sel = '0;
  logic [NM*3-1:0]   m_cti = '0;
  logic [NM-1:0]     m_ack, m_err, grant;
  logic [DW-1:0]     m_rdat, mem_wdat;
  logic [DW-1:0]     mem_rdat = '0;
  logic              mem_req, mem_we, busy;
  logic              mem_ack = 1'b0;
  logic [AW-1:0]     mem_adr;
  logic [SW-1:0]     mem_sel;

  always #5 clk = ~clk;

  hbus_wb_arbiter #(
    .NUM_MASTERS (NM), .AW (AW), .DW (DW), .TIMEOUT (TMO), .LOCK_MAX (LMAX)
  ) dut (
    .wb_clk (clk), .wb_rstn (rst_n),
    .m_cyc (m_cyc), .m_stb (m_stb), .m_we (m_we), .m_adr (m_adr),
    .m_dat (m_dat), .m_sel (m_sel), .m_cti (m_cti),
    .m_ack (m_ack), .m_err (m_err), .m_rdat (m_rdat),
    .mem_req (mem_req), .mem_we (mem_we), .mem_adr (mem_adr),
    .mem_wdat (mem_wdat), .mem_sel (mem_sel), .mem_ack (mem_ack),
    .mem_rdat (mem_rdat), .busy (busy), .grant (grant)
  );

  typedef struct packed {
    logic [2:0]  mi;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        drop;
  } txn_t;

  typedef struct packed {
    logic [2:0]  mi;
    logic        err;
    logic [31:0] rdat;
  } resp_t;

  txn_t  txq[$];
  txn_t  gq[$];
  resp_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int lat = 0;
  bit no_ack = 1'b0;
  bit prev_req = 1'b0;
  bit acked = 1'b0;
  int req_cycles = 0;
  int hold_cnt = 0;
  int n_err_seen = 0;
  logic [NM-1:0] pop_pend = '0;
  logic [NM-1:0] cur_g = '0;
  logic [31:0]   last_rd = '0;
  txn_t cur;

  function automatic int head_idx(input int mi);
    foreach (txq[k]) if (int'(txq[k].mi) == mi) return k;
    return -1;
  endfunction

  function automatic txn_t mk(input int mi, input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel,
                              input logic [2:0] cti, input logic drop);
    txn_t t;
    t.mi = 3'(mi); t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.cti = cti; t.drop = drop;
    return t;
  endfunction

  // One clock of bench activity, evaluated on the falling edge.
  task automatic step();
    int h;
    resp_t r;
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      if (pop_pend[i]) begin
        h = head_idx(i);
        if (h >= 0) txq.delete(h);
        pop_pend[i] = 1'b0;
      end
    end
    mem_ack = 1'b0;
    if (mem_req && !prev_req) begin
      n_checks++;
      if (gq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req: got mem_req adr=%h grant=%b required no request", mem_adr, grant);
      end else begin
        cur   = gq.pop_front();
        cur_g = NM'(1) << cur.mi;
        if (grant !== cur_g || mem_adr !== cur.adr || mem_we !== cur.we ||
            mem_sel !== cur.sel || (cur.we && mem_wdat !== cur.dat)) begin
          n_fail++;
          $display("FAIL grant_order: got grant=%b adr=%h we=%b sel=%h wdat=%h required grant=%b adr=%h we=%b sel=%h wdat=%h",
                   grant, mem_adr, mem_we, mem_sel, mem_wdat, cur_g, cur.adr, cur.we, cur.sel, cur.dat);
        end
      end
      req_cycles = 0;
      acked = 1'b0;
    end else if (mem_req) begin
      n_checks++;
      if (mem_adr !== cur.adr || grant !== cur_g) begin
        n_fail++;
        $display("FAIL req_stable: got adr=%h grant=%b required adr=%h grant=%b", mem_adr, grant, cur.adr, cur_g);
      end
    end
    if (mem_req) begin
      if (!no_ack && !acked && req_cycles == lat) begin
        mem_rdat = $urandom;
        mem_ack  = 1'b1;
        acked    = 1'b1;
        if (!cur.drop) begin
          r.mi = cur.mi; r.err = 1'b0; r.rdat = mem_rdat;
          rq.push_back(r);
        end
      end
      req_cycles++;
    end
    if (!mem_req && prev_req) begin
      hold_cnt = req_cycles;
      if (!acked && !cur.drop) begin
        r.mi = cur.mi; r.err = 1'b1; r.rdat = '0;
        rq.push_back(r);
      end
    end
    prev_req = mem_req;
    for (int i = 0; i < NM; i++) begin
      if (m_ack[i] || m_err[i]) begin
        n_checks++;
        if (m_err[i]) n_err_seen++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: got ack=%b err=%b on master %0d required none", m_ack[i], m_err[i], i);
        end else begin
          r = rq.pop_front();
          if (int'(r.mi) != i || r.err !== m_err[i] || (m_ack[i] && m_err[i]) ||
              (!r.err && m_rdat !== r.rdat)) begin
            n_fail++;
            $display("FAIL response: got master=%0d ack=%b err=%b rdat=%h required master=%0d err=%b rdat=%h",
                     i, m_ack[i], m_err[i], m_rdat, r.mi, r.err, r.rdat);
          end
          if (!r.err) last_rd = r.rdat;
        end
        pop_pend[i] = 1'b1;
      end
    end
    for (int i = 0; i < NM; i++) begin
      h = head_idx(i);
      if (h >= 0) begin
        m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = txq[h].we;
        m_adr[i*AW +: AW] = txq[h].adr; m_dat[i*DW +: DW] = txq[h].dat;
        m_sel[i*SW +: SW] = txq[h].sel; m_cti[i*3 +: 3] = txq[h].cti;
      end else begin
        m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
        m_cti[i*3 +: 3] = 3'b000;
      end
    end
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      if (txq.size() == 0 && gq.size() == 0 && rq.size() == 0 &&
          !mem_req && !busy && pop_pend == '0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_idle: got pending txq=%0d gq=%0d rq=%0d required all drained", tag, txq.size(), gq.size(), rq.size());
    end
  endtask

  task automatic wait_req(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (mem_req) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_wait_req: got no mem_req required mem_req within %0d cycles", tag, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    txq.delete(); gq.delete(); rq.delete();
    m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0;
    mem_ack = 1'b0; prev_req = 1'b0; pop_pend = '0;
    no_ack = 1'b0; lat = 0; n_err_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b busy=%b grant=%b required 0", mem_req, busy, grant);
    end
    n_checks++;
    if (m_ack !== '0 || m_err !== '0 || m_rdat !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got ack=%b err=%b rdat=%h required 0", m_ack, m_err, m_rdat);
    end
    n_checks++;
    if (mem_adr !== '0 || mem_we !== 1'b0 || mem_wdat !== '0 || mem_sel !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got adr=%h we=%b wdat=%h sel=%h required 0", mem_adr, mem_we, mem_wdat, mem_sel);
    end
  endtask

  task automatic test_single_read();
    txn_t t;
    do_reset();
    lat = 5;
    t = mk(1, 1'b0, 32'h1000_0040, 32'h0, 4'hF, 3'b000, 1'b0);
    txq.push_back(t); gq.push_back(t);
    run_until_idle(40, "single_read");
    n_checks++;
    if (hold_cnt != 6) begin
      n_fail++;
      $display("FAIL single_read_hold: got %0d cycles required 6", hold_cnt);
    end
  endtask

  task automatic test_round_robin();
    txn_t t;
    do_reset();
    lat = 1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NM; i++) begin
        t = mk(i, (i == 1 && r == 0), 32'h2000_0000 + 32'(i * 256 + r * 4),
               32'hC0DE_0000 + 32'(i), (r == 0) ? 4'hF : 4'h3, 3'b000, 1'b0);
        txq.push_back(t); gq.push_back(t);
      end
    end
    run_until_idle(80, "round_robin");
  endtask

  task automatic test_burst_lock();
    txn_t t;
    txn_t b[$];
    txn_t a0, a1;
    do_reset();
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      t = mk(2, 1'b0, 32'h3000_0000 + 32'(k * 4), 32'h0, 4'hF, (k == 19) ? 3'b111 : 3'b010, 1'b0);
      txq.push_back(t); b.push_back(t);
    end
    a0 = mk(0, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 3'b000, 1'b0);
    a1 = mk(0, 1'b0, 32'h4000_0004, 32'h0, 4'hF, 3'b000, 1'b0);
    for (int k = 0; k < 16; k++) gq.push_back(b[k]);
    gq.push_back(a0);
    for (int k = 16; k < 20; k++) gq.push_back(b[k]);
    gq.push_back(a1);
    wait_req(10, "burst");
    txq.push_back(a0); txq.push_back(a1);
    run_until_idle(300, "burst");
  endtask

  task automatic test_timeout();
    txn_t t;
    logic [31:0] rd0;
    do_reset();
    lat = 2;
    t = mk(1, 1'b0, 32'h5000_0000, 32'h0, 4'hF, 3'b000, 1'b0);
    txq.push_back(t); gq.push_back(t);
    run_until_idle(40, "tmo_pre");
    rd0 = last_rd;
    no_ack = 1'b1;
    n_err_seen = 0;
    t = mk(0, 1'b0, 32'h5000_0100, 32'h0, 4'hF, 3'b000, 1'b0);
    txq.push_back(t); gq.push_back(t);
    run_until_idle(60, "timeout");
    n_checks++;
    if (hold_cnt != TMO) begin
      n_fail++;
      $display("FAIL timeout_hold: got %0d cycles required %0d", hold_cnt, TMO);
    end
    n_checks++;
    if (n_err_seen != 1) begin
      n_fail++;
      $display("FAIL timeout_err_count: got %0d required 1", n_err_seen);
    end
    step(); step();
    mem_rdat = ~rd0;
    mem_ack  = 1'b1;
    step(); step(); step();
    n_checks++;
    if (m_rdat !== rd0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: got rdat=%h busy=%b req=%b required rdat=%h busy=0 req=0", m_rdat, busy, mem_req, rd0);
    end
    no_ack = 1'b0;
  endtask

  task automatic test_abort();
    txn_t t0, t1;
    int h;
    do_reset();
    lat = 4;
    t0 = mk(0, 1'b0, 32'h6000_0000, 32'h0, 4'hF, 3'b000, 1'b1);
    t1 = mk(1, 1'b0, 32'h6000_0100, 32'h0, 4'hF, 3'b000, 1'b0);
    txq.push_back(t0); txq.push_back(t1);
    gq.push_back(t0); gq.push_back(t1);
    wait_req(10, "abort");
    step(); step();
    h = head_idx(0);
    if (h >= 0) txq.delete(h);
    step();
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_req_held: got mem_req=%b required 1", mem_req);
    end
    run_until_idle(60, "abort");
  endtask

  task automatic test_reset_during_req();
    txn_t t;
    do_reset();
    lat = 1;
    t = mk(1, 1'b0, 32'h7000_0000, 32'h0, 4'hF, 3'b000, 1'b0);
    txq.push_back(t); gq.push_back(t);
    run_until_idle(40, "rst_pre");
    lat = 30;
    t = mk(2, 1'b0, 32'h7000_0200, 32'h0, 4'hF, 3'b000, 1'b0);
    txq.push_back(t); gq.push_back(t);
    t = mk(1, 1'b0, 32'h7000_0104, 32'h0, 4'hF, 3'b000, 1'b0);
    txq.push_back(t);
    wait_req(10, "rst_req");
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b grant=%b busy=%b required 0", mem_req, grant, busy);
    end
    gq.delete(); rq.delete();
    prev_req = 1'b0; pop_pend = '0; mem_ack = 1'b0;
    lat = 1;
    gq.push_back(mk(1, 1'b0, 32'h7000_0104, 32'h0, 4'hF, 3'b000, 1'b0));
    gq.push_back(mk(2, 1'b0, 32'h7000_0200, 32'h0, 4'hF, 3'b000, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_until_idle(60, "rst_after");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_lock();
    test_timeout();
    test_abort();
    test_reset_during_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
